// File: rtl/system_onchip_mem_stream_writer.sv
// Packs a 32-bit valid/ready stream into 64-bit little-endian words and writes them
// to consecutive addresses of a zero-wait-state on-chip memory.
module system_onchip_mem_stream_writer #(
    parameter int ADDR_WIDTH = 13,
    parameter int CNT_WIDTH  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_words,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [7:0]            byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [63:0]           writedata
);

    typedef enum logic [2:0] {IDLE, LO, HI, WR, FIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_WIDTH-1:0]  rem_q;
    logic [31:0]           pack_lo;

    // Ready depends on state only, so there is no combinational path from in_valid.
    always_comb begin
        in_ready = 1'b0;
        if (state == LO || state == HI)
            in_ready = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            pack_lo    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            address    <= '0;
            byteenable <= '0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
        end else begin
            chipselect <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            addr_q <= base_addr;
                            rem_q  <= num_words;
                            busy   <= 1'b1;
                            state  <= LO;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FIN;
                        end
                    end
                end
                LO: begin
                    if (in_valid) begin
                        pack_lo <= in_data;
                        rem_q   <= rem_q - CNT_WIDTH'(1);
                        if (rem_q == CNT_WIDTH'(1)) begin
                            // Lone final word: upper half zeroed, only low bytes enabled.
                            chipselect <= 1'b1;
                            write      <= 1'b1;
                            byteenable <= 8'h0F;
                            address    <= addr_q;
                            writedata  <= {32'h0, in_data};
                            state      <= WR;
                        end else begin
                            state <= HI;
                        end
                    end
                end
                HI: begin
                    if (in_valid) begin
                        rem_q      <= rem_q - CNT_WIDTH'(1);
                        chipselect <= 1'b1;
                        write      <= 1'b1;
                        byteenable <= 8'hFF;
                        address    <= addr_q;
                        writedata  <= {in_data, pack_lo};
                        state      <= WR;
                    end
                end
                WR: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    if (rem_q != '0) begin
                        state <= LO;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_system_onchip_mem_stream_writer.sv
// Directed self-checking bench for system_onchip_mem_stream_writer.
module tb_system_onchip_mem_stream_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic [14:0] num_words;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [12:0] address;
    logic [7:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [63:0] writedata;

    system_onchip_mem_stream_writer #(.ADDR_WIDTH(13), .CNT_WIDTH(15)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .address(address),
        .byteenable(byteenable), .chipselect(chipselect), .write(write),
        .writedata(writedata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_busy = 1'b0;
    int strobe_err = 0;
    logic [12:0] wa[$];
    logic [7:0]  wbe[$];
    logic [63:0] wd[$];
    int          wcyc[$];
    logic        wbusy[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done recorder, sampled on the falling edge.
    always @(negedge clk) begin
        if (write) begin
            wa.push_back(address);
            wbe.push_back(byteenable);
            wd.push_back(writedata);
            wcyc.push_back(cyc);
            wbusy.push_back(busy);
        end
        if (done) begin
            done_cnt  = done_cnt + 1;
            done_cyc  = cyc;
            done_busy = busy;
        end
        if ((chipselect !== write) || (!write && byteenable != 8'h00))
            strobe_err = strobe_err + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input logic [31:0] seed, input int i);
        return seed + 32'(i) * 32'h11111111;
    endfunction

    task automatic pulse_start(input logic [12:0] b, input logic [14:0] n, output int s);
        start     = 1'b1;
        base_addr = b;
        num_words = n;
        s         = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic stream(input logic [31:0] seed, input int n, input bit gaps);
        int idx = 0;
        int budget = 400;
        bit acc;
        while (idx < n && budget > 0) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = word(seed, idx);
            end
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
            budget--;
        end
        in_valid = 1'b0;
        check("stream_words", 64'(idx), 64'(n));
    endtask

    task automatic wait_done(input int prev);
        int budget = 100;
        while (done_cnt == prev && budget > 0) begin
            step();
            budget--;
        end
        check("done_seen", 64'(done_cnt), 64'(prev + 1));
    endtask

    task automatic chk_wr(input string tag, input int k, input logic [12:0] a,
                          input logic [7:0] be, input logic [63:0] d);
        if (k < wa.size()) begin
            check({tag, "_addr"}, 64'(wa[k]), 64'(a));
            check({tag, "_be"}, 64'(wbe[k]), 64'(be));
            check({tag, "_data"}, wd[k], d);
        end else begin
            check({tag, "_present"}, 64'(wa.size()), 64'(k + 1));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_cs"}, 64'(chipselect), 64'(0));
        check({tag, "_write"}, 64'(write), 64'(0));
        check({tag, "_addr"}, 64'(address), 64'(0));
        check({tag, "_be"}, 64'(byteenable), 64'(0));
        check({tag, "_wdata"}, writedata, 64'(0));
    endtask

    initial begin
        int s;
        int q0;
        int d0;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        in_valid = 1'b0; in_data = '0;
        step();
        chk_idle_outputs("rst");
        reset = 1'b0;
        step();

        // 1: reset while a pair is half packed
        pulse_start(13'h100, 15'd4, s);
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        check("mid_hi_ready", 64'(in_ready), 64'(1));
        reset = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        step();
        reset = 1'b0;
        repeat (3) step();
        chk_idle_outputs("post_rst");
        check("post_rst_writes", 64'(wa.size()), 64'(0));
        check("post_rst_done", 64'(done_cnt), 64'(0));
        q0 = wa.size(); d0 = done_cnt;
        pulse_start(13'h000, 15'd2, s);
        stream(32'h01020304, 2, 1'b0);
        wait_done(d0);
        chk_wr("t1", q0, 13'h000, 8'hFF, 64'h12131415_01020304);
        step();

        // 2: two full pairs, gap-free
        q0 = wa.size(); d0 = done_cnt;
        pulse_start(13'h010, 15'd4, s);
        check("t2_busy", 64'(busy), 64'(1));
        stream(32'h11111111, 4, 1'b0);
        wait_done(d0);
        chk_wr("t2_w0", q0, 13'h010, 8'hFF, 64'h22222222_11111111);
        chk_wr("t2_w1", q0 + 1, 13'h011, 8'hFF, 64'h44444444_33333333);
        check("t2_nwr", 64'(wa.size() - q0), 64'(2));
        if (wa.size() - q0 == 2) begin
            check("t2_w0_lat", 64'(wcyc[q0] - s), 64'(3));
            check("t2_w_gap", 64'(wcyc[q0 + 1] - wcyc[q0]), 64'(3));
            check("t2_done_lat", 64'(done_cyc - wcyc[q0 + 1]), 64'(1));
        end
        check("t2_done_busy", 64'(done_busy), 64'(0));
        step();
        check("t2_done_pulse", 64'(done), 64'(0));

        // 3: odd count, final write is half width
        q0 = wa.size(); d0 = done_cnt;
        pulse_start(13'h005, 15'd3, s);
        stream(32'h10000001, 3, 1'b0);
        wait_done(d0);
        chk_wr("t3_w0", q0, 13'h005, 8'hFF, 64'h21111112_10000001);
        chk_wr("t3_w1", q0 + 1, 13'h006, 8'h0F, 64'h00000000_32222223);
        step();

        // 4: address wraps past the top of memory
        q0 = wa.size(); d0 = done_cnt;
        pulse_start(13'h1FFF, 15'd4, s);
        stream(32'h00000001, 4, 1'b0);
        wait_done(d0);
        chk_wr("t4_w0", q0, 13'h1FFF, 8'hFF, 64'h11111112_00000001);
        chk_wr("t4_w1", q0 + 1, 13'h0000, 8'hFF, 64'h33333334_22222223);
        step();

        // 5: zero-length transfer
        q0 = wa.size(); d0 = done_cnt;
        pulse_start(13'h055, 15'd0, s);
        check("t5_done", 64'(done), 64'(1));
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_done_cyc", 64'(done_cyc - s), 64'(1));
        repeat (3) step();
        check("t5_done_once", 64'(done_cnt - d0), 64'(1));
        check("t5_nwr", 64'(wa.size() - q0), 64'(0));

        // 6: random valid gaps, extra starts while busy and in FIN
        q0 = wa.size(); d0 = done_cnt;
        pulse_start(13'h020, 15'd5, s);
        fork
            stream(32'h0A0B0C0D, 5, 1'b1);
            begin
                repeat (2) step();
                start = 1'b1; base_addr = 13'h777; num_words = 15'd9;
                step();
                start = 1'b0;
                repeat (2) step();
                start = 1'b1;
                step();
                start = 1'b0;
            end
        join
        wait_done(d0);
        check("t6_fin_ready", 64'(in_ready), 64'(0));
        start = 1'b1; base_addr = 13'h777; num_words = 15'd9;
        step();
        start = 1'b0;
        repeat (4) step();
        check("t6_busy_after", 64'(busy), 64'(0));
        check("t6_done_once", 64'(done_cnt - d0), 64'(1));
        check("t6_nwr", 64'(wa.size() - q0), 64'(3));
        chk_wr("t6_w0", q0, 13'h020, 8'hFF, 64'h1B1C1D1E_0A0B0C0D);
        chk_wr("t6_w1", q0 + 1, 13'h021, 8'hFF, 64'h3D3E3F40_2C2D2E2F);
        chk_wr("t6_w2", q0 + 2, 13'h022, 8'h0F, 64'h00000000_4E4F5051);
        for (int k = q0; k < wa.size(); k++)
            check("t6_busy_at_wr", 64'(wbusy[k]), 64'(1));
        check("t6_done_busy", 64'(done_busy), 64'(0));

        check("strobes_only_in_wr", 64'(strobe_err), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
